tlk2711_rx_deframer: RTL and testbench
======================================

Name: tlk2711_rx_deframer

Overview:
Receive-side companion to the TLK2711 transmit controller. It consumes the SerDes parallel output (i_rxd, i_rkmsb, i_rklsb) in the rx_clk domain and acquires word sync on the K28.5/D5.6 comma idle. It then delineates frames on the K28.5/D11.5 SOF word and emits the payload words with sof/eof markers. An optional checker verifies the incrementing test pattern the transmitter sends and keeps frame and error counters for link bring-up.

Parameters:
FRAME_LEN, 32, payload words per frame after SOF (>=2)
SYNC_CNT, 2, consecutive comma words required to declare sync (>=1)
CHECK_EN, 1, 1 enables payload pattern check, 0 disables o_data_err and pattern counting
CNT_W, 16, width of o_frame_cnt and o_err_cnt

Ports:
rx_clk  in  1  receive clock, single clock domain
rst  in  1  synchronous reset, active-high
i_rxd  in  16  received word, [15:8] msb byte, [7:0] lsb byte
i_rkmsb  in  1  msb byte is K code
i_rklsb  in  1  lsb byte is K code
i_clr_cnt  in  1  synchronous clear of o_frame_cnt and o_err_cnt
o_data  out  16  payload word
o_valid  out  1  o_data valid
o_sof  out  1  first payload word of frame, qualified by o_valid
o_eof  out  1  last payload word of frame, qualified by o_valid
o_synced  out  1  word sync acquired
o_frame_err  out  1  one-cycle pulse, frame aborted early
o_data_err  out  1  one-cycle pulse with o_valid, pattern mismatch
o_frame_cnt  out  CNT_W  completed frames, saturating
o_err_cnt  out  CNT_W  frame_err plus data_err events, saturating

Behaviour:
- Clock and reset: one clock, rx_clk. Reset rst is synchronous and active-high.
- Word classes (combinational):
  - COMMA: rkmsb=1, rklsb=0, rxd=0xBCC5.
  - SOF: rkmsb=1, rklsb=0, rxd=0xBCAB.
  - DATA: rkmsb=0, rklsb=0.
  - OTHER: anything else.
- Reset: state UNSYNC_s, comma count 0, word index 0, all outputs 0. Reset mid-frame drops the frame with no eof and no frame_err.
- Latency: all outputs are registered, one cycle after the input word.
- UNSYNC_s, o_synced=0:
  - COMMA increments comma_cnt.
  - Any non-COMMA clears comma_cnt.
  - When comma_cnt reaches SYNC_CNT, go to SYNC_s. o_synced=1 from the next cycle.
- SYNC_s:
  - COMMA: stay.
  - DATA: ignored, no error.
  - SOF: go to PAYLOAD_s, idx=0.
  - OTHER: go to UNSYNC_s, o_synced=0, comma_cnt=0.
- PAYLOAD_s, DATA word:
  - o_valid=1, o_data=i_rxd.
  - o_sof=(idx==0), o_eof=(idx==FRAME_LEN-1).
  - idx increments.
  - At idx==FRAME_LEN-1: o_frame_cnt+1, go to SYNC_s.
- PAYLOAD_s, any K/OTHER word before completion:
  - o_frame_err=1, o_err_cnt+1, no o_valid.
  - COMMA: go to SYNC_s.
  - SOF: restart PAYLOAD_s with idx=0.
  - OTHER: go to UNSYNC_s.
- Pattern check (CHECK_EN=1):
  - Expected word = {3'b0,idx[4:0],3'b0,idx[4:0]}, i.e. the payload index repeated in both bytes.
  - Mismatch: o_data_err=1 in the same cycle as o_valid, o_err_cnt+1.
  - frame_err and data_err are exclusive by construction, so there is at most one increment per cycle.
- Counters:
  - Saturate at all-ones.
  - i_clr_cnt clears both counters and has priority over a same-cycle increment.

Decomposition:
- Package tlk2711_pkg:
  - K28_5=8'hBC, D5_6=8'hC5, D11_5=8'hAB.
  - Word-class enum {W_COMMA, W_SOF, W_DATA, W_OTHER}.
  - Rx state enum {UNSYNC_s, SYNC_s, PAYLOAD_s}.
  - The transmit controller shares the same constants.
- Sub-module tlk2711_rx_classify: purely combinational word classifier (i_rxd, i_rkmsb, i_rklsb -> word class). FSM, checker and counters stay in the top module.

Test Plan:
- Acquisition: 1 comma, 1 DATA, then 2 commas -> o_synced rises one cycle after the 2nd consecutive comma only, not after the 1st.
- Good frame: sync, SOF, 32 DATA words 0x0000,0x0101..0x1F1F -> 32 o_valid cycles.
  - o_sof on 0x0000, o_eof on 0x1F1F.
  - o_frame_cnt=1, o_err_cnt=0, no o_data_err.
- Pattern error: as above, but word 5 = 0x0506 -> o_data_err only on that o_valid cycle, o_err_cnt=1, o_frame_cnt=1.
- Truncated frame: SOF, 10 DATA, SOF, 32 good DATA -> o_frame_err one pulse at the 2nd SOF.
  - Second frame restarts at o_sof with 0x0000 and completes.
  - o_frame_cnt=1, o_err_cnt=1.
- Loss of sync: in PAYLOAD_s, feed rkmsb=1, rklsb=1, 0xFEFE -> o_frame_err pulse, o_synced=0 next cycle.
  - Following DATA words produce no o_valid until 2 commas are received.
- Reset/clear: rst asserted mid-frame -> all outputs 0 next cycle, no eof.
  - Separately, i_clr_cnt coincident with an eof -> o_frame_cnt=0.
  - Counter saturation checked with CNT_W=2: after 5 errors, o_err_cnt=3.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link constants and types for the transmit controller and the
// receive deframer.
package tlk2711_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D11_5 = 8'hAB;

    localparam logic [15:0] COMMA_WORD = {K28_5, D5_6};
    localparam logic [15:0] SOF_WORD   = {K28_5, D11_5};

    typedef enum logic [1:0] {
        W_COMMA,
        W_SOF,
        W_DATA,
        W_OTHER
    } word_class_t;

    typedef enum logic [1:0] {
        UNSYNC_s,
        SYNC_s,
        PAYLOAD_s
    } rx_state_t;

    // Test payload word: the low five bits of the payload index in both bytes.
    function automatic logic [15:0] test_word(input logic [4:0] idx);
        return {3'b000, idx, 3'b000, idx};
    endfunction

endpackage

// File: rtl/tlk2711_rx_classify.sv
// Combinational classifier for one received SerDes word: comma idle, SOF,
// plain data, or anything else.
module tlk2711_rx_classify
    import tlk2711_pkg::*;
(
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    output word_class_t o_class
);

    always_comb begin
        o_class = W_OTHER;
        if (!i_rkmsb && !i_rklsb)
            o_class = W_DATA;
        else if (i_rkmsb && !i_rklsb && i_rxd == COMMA_WORD)
            o_class = W_COMMA;
        else if (i_rkmsb && !i_rklsb && i_rxd == SOF_WORD)
            o_class = W_SOF;
    end

endmodule

// File: rtl/tlk2711_rx_deframer.sv
// TLK2711 receive deframer: comma-based word sync, SOF-delimited frames,
// optional incrementing-pattern check and saturating link counters.
module tlk2711_rx_deframer
    import tlk2711_pkg::*;
#(
    parameter int FRAME_LEN = 32,
    parameter int SYNC_CNT  = 2,
    parameter int CHECK_EN  = 1,
    parameter int CNT_W     = 16
) (
    input  logic             rx_clk,
    input  logic             rst,
    input  logic [15:0]      i_rxd,
    input  logic             i_rkmsb,
    input  logic             i_rklsb,
    input  logic             i_clr_cnt,
    output logic [15:0]      o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_synced,
    output logic             o_frame_err,
    output logic             o_data_err,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int CC_W  = $clog2(SYNC_CNT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CC_W-1:0]  SYNC_LAST = CC_W'(SYNC_CNT - 1);

    word_class_t      wcls;
    rx_state_t        state, state_nxt;
    logic [CC_W-1:0]  comma_cnt, comma_cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [4:0]       idx5;

    logic        valid_d, sof_d, eof_d, synced_d, ferr_d, derr_d;
    logic [15:0] data_d;

    tlk2711_rx_classify u_classify (
        .i_rxd   (i_rxd),
        .i_rkmsb (i_rkmsb),
        .i_rklsb (i_rklsb),
        .o_class (wcls)
    );

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state     <= UNSYNC_s;
            comma_cnt <= '0;
            idx       <= '0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_cnt_nxt;
            idx       <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        idx_nxt       = idx;
        case (state)
            UNSYNC_s: begin
                if (wcls == W_COMMA) begin
                    if (comma_cnt == SYNC_LAST) begin
                        state_nxt     = SYNC_s;
                        comma_cnt_nxt = '0;
                    end else begin
                        comma_cnt_nxt = comma_cnt + CC_W'(1);
                    end
                end else begin
                    comma_cnt_nxt = '0;
                end
            end
            SYNC_s: begin
                case (wcls)
                    W_SOF: begin
                        state_nxt = PAYLOAD_s;
                        idx_nxt   = '0;
                    end
                    W_OTHER: begin
                        state_nxt     = UNSYNC_s;
                        comma_cnt_nxt = '0;
                    end
                    default: ;
                endcase
            end
            PAYLOAD_s: begin
                case (wcls)
                    W_DATA: begin
                        if (idx == LAST_IDX) begin
                            state_nxt = SYNC_s;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                    W_COMMA: begin
                        state_nxt = SYNC_s;
                        idx_nxt   = '0;
                    end
                    W_SOF: idx_nxt = '0;
                    default: begin
                        state_nxt     = UNSYNC_s;
                        comma_cnt_nxt = '0;
                        idx_nxt       = '0;
                    end
                endcase
            end
            default: begin
                state_nxt     = UNSYNC_s;
                comma_cnt_nxt = '0;
                idx_nxt       = '0;
            end
        endcase
    end

    assign idx5 = 5'(idx);

    // Next values of the registered outputs; frame_err and data_err can never
    // coincide because one needs a K word and the other a data word.
    always_comb begin
        valid_d  = (state == PAYLOAD_s) && (wcls == W_DATA);
        sof_d    = valid_d && (idx == '0);
        eof_d    = valid_d && (idx == LAST_IDX);
        ferr_d   = (state == PAYLOAD_s) && (wcls != W_DATA);
        derr_d   = (CHECK_EN != 0) && valid_d && (i_rxd != test_word(idx5));
        data_d   = valid_d ? i_rxd : 16'h0000;
        synced_d = (state_nxt != UNSYNC_s);
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_synced    <= 1'b0;
            o_frame_err <= 1'b0;
            o_data_err  <= 1'b0;
        end else begin
            o_data      <= data_d;
            o_valid     <= valid_d;
            o_sof       <= sof_d;
            o_eof       <= eof_d;
            o_synced    <= synced_d;
            o_frame_err <= ferr_d;
            o_data_err  <= derr_d;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst || i_clr_cnt) begin
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            if (eof_d && o_frame_cnt != '1)
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            if ((ferr_d || derr_d) && o_err_cnt != '1)
                o_err_cnt <= o_err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Bench for tlk2711_rx_deframer: vector table plus scripted frame sequences,
// expected outputs queued at drive time and checked one cycle later.
module tb_tlk2711_rx_deframer;

    logic        rx_clk = 1'b0;
    logic        rst;
    logic [15:0] rxd;
    logic        rkm, rkl, clr;

    logic [15:0] o_data;
    logic        o_valid, o_sof, o_eof, o_synced, o_frame_err, o_data_err;
    logic [15:0] o_frame_cnt, o_err_cnt;

    logic [15:0] s_data;
    logic        s_valid, s_sof, s_eof, s_synced, s_frame_err, s_data_err;
    logic [1:0]  s_frame_cnt, s_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 rx_clk = ~rx_clk;

    tlk2711_rx_deframer dut (
        .rx_clk(rx_clk), .rst(rst), .i_rxd(rxd), .i_rkmsb(rkm), .i_rklsb(rkl),
        .i_clr_cnt(clr), .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof),
        .o_eof(o_eof), .o_synced(o_synced), .o_frame_err(o_frame_err),
        .o_data_err(o_data_err), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    tlk2711_rx_deframer #(.CNT_W(2)) dut_sat (
        .rx_clk(rx_clk), .rst(rst), .i_rxd(rxd), .i_rkmsb(rkm), .i_rklsb(rkl),
        .i_clr_cnt(clr), .o_data(s_data), .o_valid(s_valid), .o_sof(s_sof),
        .o_eof(s_eof), .o_synced(s_synced), .o_frame_err(s_frame_err),
        .o_data_err(s_data_err), .o_frame_cnt(s_frame_cnt), .o_err_cnt(s_err_cnt)
    );

    typedef struct {
        logic        rkm, rkl, clr;
        logic [15:0] rxd;
        logic        valid, sof, eof, derr, ferr, synced;
        logic [15:0] data;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[6];
    int   vec_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic k1, input logic k0, input logic [15:0] w,
                                input logic c, input logic v, input logic s, input logic e,
                                input logic de, input logic fe, input logic sy,
                                input logic [15:0] d);
        vec_t r;
        r.rkm = k1; r.rkl = k0; r.rxd = w; r.clr = c;
        r.valid = v; r.sof = s; r.eof = e; r.derr = de; r.ferr = fe; r.synced = sy;
        r.data = d;
        return r;
    endfunction

    function automatic logic [15:0] pat(input int i);
        logic [4:0] b;
        b = i[4:0];
        return {3'b000, b, 3'b000, b};
    endfunction

    function automatic vec_t comma_v(input logic sy, input logic c);
        return mk(1, 0, 16'hBCC5, c, 0, 0, 0, 0, 0, sy, 16'h0);
    endfunction

    function automatic vec_t sof_v(input logic fe);
        return mk(1, 0, 16'hBCAB, 0, 0, 0, 0, 0, fe, 1, 16'h0);
    endfunction

    function automatic vec_t pay_v(input int i, input logic [15:0] w, input logic de);
        return mk(0, 0, w, 0, 1, i == 0, i == 31, de, 0, 1, w);
    endfunction

    function automatic vec_t idle_v(input logic [15:0] w, input logic sy);
        return mk(0, 0, w, 0, 0, 0, 0, 0, 0, sy, 16'h0);
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        logic [63:0] act, exp;
        rxd = v.rxd; rkm = v.rkm; rkl = v.rkl; clr = v.clr;
        sb.push_back(v);
        @(posedge rx_clk);
        #1;
        vec_no++;
        if (sb.size() == 0) begin
            chk($sformatf("scoreboard_empty#%0d", vec_no), 64'd1, 64'd0);
        end else begin
            e   = sb.pop_front();
            act = {42'h0, o_valid, o_sof, o_eof, o_data_err, o_frame_err, o_synced,
                   o_valid ? o_data : 16'h0};
            exp = {42'h0, e.valid, e.sof, e.eof, e.derr, e.ferr, e.synced,
                   e.valid ? e.data : 16'h0};
            chk($sformatf("vec#%0d", vec_no), act, exp);
        end
        clr = 1'b0;
    endtask

    task automatic send_frame(input int n, input int bad, input logic [15:0] badw);
        for (int i = 0; i < n; i++)
            step(pay_v(i, (i == bad) ? badw : pat(i), i == bad));
    endtask

    task automatic chk_cnt(input string name, input int frames, input int errs);
        chk({name, "_frame_cnt"}, 64'(o_frame_cnt), 64'(frames));
        chk({name, "_err_cnt"}, 64'(o_err_cnt), 64'(errs));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {10'h0, o_valid, o_sof, o_eof, o_synced, o_frame_err, o_data_err,
                   o_data, o_frame_cnt, o_err_cnt}, 64'h0);
    endtask

    initial begin
        // acquisition: a lone comma must not sync, two consecutive must
        tbl[0] = comma_v(0, 0);
        tbl[1] = idle_v(16'h1234, 0);
        tbl[2] = comma_v(0, 0);
        tbl[3] = comma_v(1, 0);
        tbl[4] = idle_v(16'h5678, 1);
        tbl[5] = comma_v(1, 0);

        rst = 1'b1; rxd = 16'h0; rkm = 1'b0; rkl = 1'b0; clr = 1'b0;
        repeat (2) @(posedge rx_clk);
        #1;
        chk_all_zero("reset_state");
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // good frame
        step(sof_v(0));
        send_frame(32, -1, 16'h0);
        chk_cnt("good", 1, 0);

        // pattern error on word 5
        step(comma_v(1, 1));
        chk_cnt("clear", 0, 0);
        step(sof_v(0));
        send_frame(32, 5, 16'h0506);
        chk_cnt("pattern", 1, 1);

        // truncated frame restarted by a second SOF
        step(comma_v(1, 1));
        step(sof_v(0));
        send_frame(10, -1, 16'h0);
        step(sof_v(1));
        send_frame(32, -1, 16'h0);
        chk_cnt("truncated", 1, 1);

        // loss of sync on an invalid K word
        step(comma_v(1, 1));
        step(sof_v(0));
        send_frame(3, -1, 16'h0);
        step(mk(1, 1, 16'hFEFE, 0, 0, 0, 0, 0, 1, 0, 16'h0));
        for (int i = 3; i < 6; i++) step(idle_v(pat(i), 0));
        step(comma_v(0, 0));
        step(comma_v(1, 0));
        chk_cnt("los", 0, 1);

        // reset mid-frame
        step(sof_v(0));
        send_frame(5, -1, 16'h0);
        rst = 1'b1; rxd = pat(5); rkm = 1'b0; rkl = 1'b0;
        @(posedge rx_clk);
        #1;
        chk_all_zero("reset_midframe");
        rst = 1'b0;
        step(idle_v(pat(6), 0));
        step(comma_v(0, 0));
        step(comma_v(1, 0));

        // clear coincident with eof wins over the increment
        step(sof_v(0));
        send_frame(32, -1, 16'h0);
        chk("pre_clear_frame_cnt", 64'(o_frame_cnt), 64'd1);
        step(sof_v(0));
        send_frame(31, -1, 16'h0);
        begin
            vec_t v;
            v = pay_v(31, pat(31), 0);
            v.clr = 1'b1;
            step(v);
        end
        chk("clr_at_eof_frame_cnt", 64'(o_frame_cnt), 64'd0);

        // error counter saturation on the narrow-counter instance
        step(comma_v(1, 1));
        step(sof_v(0));
        repeat (5) step(sof_v(1));
        chk("wide_err_cnt", 64'(o_err_cnt), 64'd5);
        chk("sat_err_cnt", 64'(s_err_cnt), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
